// File: rtl/axi_gpio_pkg.sv
// Register map, response code and FSM encodings shared by the AXI-Lite GPIO slave.
package axi_gpio_pkg;

    // Word index taken from address bits [3:2]
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_IER  = 2'd2;
    localparam logic [1:0] ADDR_ISR  = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACK,
        R_DATA
    } rd_state_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchronizer plus a history flop for per-bit rising-edge detection.
module gpio_sync_edge #(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [GPIO_WIDTH-1:0] i_async,
    output logic [GPIO_WIDTH-1:0] o_sync,
    output logic [GPIO_WIDTH-1:0] o_rise
);

    logic [GPIO_WIDTH-1:0] r_meta;
    logic [GPIO_WIDTH-1:0] r_sync;
    logic [GPIO_WIDTH-1:0] r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/axi_lite_gpio_irq_slave.sv
// AXI4-Lite slave owning the GPIO data/direction latches and the rising-edge interrupt block.
module axi_lite_gpio_irq_slave
    import axi_gpio_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int GPIO_WIDTH         = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [GPIO_WIDTH-1:0]           gpio_i,
    output logic [GPIO_WIDTH-1:0]           gpio_o,
    output logic [GPIO_WIDTH-1:0]           gpio_t,
    output logic                            irq
);

    wr_state_e             r_wstate;
    rd_state_e             r_rstate;
    logic                  r_wr_ready;
    logic                  r_bvalid;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rd_idx;

    logic [GPIO_WIDTH-1:0] r_gpio_out;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_ier;
    logic [GPIO_WIDTH-1:0] r_isr;
    logic                  r_irq;

    logic [GPIO_WIDTH-1:0] w_sync_in;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [31:0]           w_mask32;
    logic [GPIO_WIDTH-1:0] w_wmask;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_isr_clr;
    logic [1:0]            w_wr_idx;
    logic                  w_wr_en;
    logic [31:0]           w_rd_val;
    logic                  w_unused;

    gpio_sync_edge #(
        .GPIO_WIDTH (GPIO_WIDTH)
    ) u_sync_edge (
        .i_clk   (S_AXI_ACLK),
        .i_rst_n (S_AXI_ARESETN),
        .i_async (gpio_i),
        .o_sync  (w_sync_in),
        .o_rise  (w_rise)
    );

    assign w_mask32  = strb_to_mask(S_AXI_WSTRB);
    assign w_wmask   = w_mask32[GPIO_WIDTH-1:0];
    assign w_wdata   = S_AXI_WDATA[GPIO_WIDTH-1:0];
    assign w_wr_idx  = S_AXI_AWADDR[3:2];
    assign w_wr_en   = r_wr_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_isr_clr = (w_wr_en && w_wr_idx == ADDR_ISR) ? (w_wdata & w_wmask) : '0;

    // Ready is raised one cycle after both valids are seen; the update happens on the handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate   <= W_IDLE;
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_wr_ready) begin
                        r_wr_ready <= 1'b0;
                        if (w_wr_en) begin
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end
                    end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        r_wr_ready <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_gpio_out <= '0;
            r_dir      <= '0;
            r_ier      <= '0;
            r_isr      <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_en) begin
                case (w_wr_idx)
                    ADDR_DATA: r_gpio_out <= (r_gpio_out & ~w_wmask) | (w_wdata & w_wmask);
                    ADDR_DIR:  r_dir      <= (r_dir & ~w_wmask) | (w_wdata & w_wmask);
                    ADDR_IER:  r_ier      <= (r_ier & ~w_wmask) | (w_wdata & w_wmask);
                    default:   ;
                endcase
            end
            // A same-cycle edge overrides a write-1-to-clear
            r_isr <= (r_isr & ~w_isr_clr) | w_rise;
            r_irq <= |(r_isr & r_ier);
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (r_rd_idx)
            ADDR_DATA: w_rd_val[GPIO_WIDTH-1:0] = (r_gpio_out & r_dir) | (w_sync_in & ~r_dir);
            ADDR_DIR:  w_rd_val[GPIO_WIDTH-1:0] = r_dir;
            ADDR_IER:  w_rd_val[GPIO_WIDTH-1:0] = r_ier;
            ADDR_ISR:  w_rd_val[GPIO_WIDTH-1:0] = r_isr;
            default:   w_rd_val = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rd_idx  <= ADDR_DATA;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_arready <= 1'b1;
                        r_rd_idx  <= S_AXI_ARADDR[3:2];
                        r_rstate  <= R_ACK;
                    end
                end
                R_ACK: begin
                    r_arready <= 1'b0;
                    r_rdata   <= w_rd_val;
                    r_rvalid  <= 1'b1;
                    r_rstate  <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = r_wr_ready;
    assign S_AXI_WREADY  = r_wr_ready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign gpio_o        = r_gpio_out;
    assign gpio_t        = ~r_dir;
    assign irq           = r_irq;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        S_AXI_WDATA, w_mask32};

endmodule

// File: tb/tb_axi_lite_gpio_irq_slave.sv
// Directed and randomized checks of the AXI-Lite GPIO slave against a register-level model.
module tb_axi_lite_gpio_irq_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_t;
    logic        irq;

    always #5 clk = ~clk;

    axi_lite_gpio_irq_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .GPIO_WIDTH         (32)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .gpio_i        (gpio_i),
        .gpio_o        (gpio_o),
        .gpio_t        (gpio_t),
        .irq           (irq)
    );

    int errors = 0;
    int checks = 0;

    // Register-level model: output latch, direction, enables, status and the settled pin values
    logic [31:0] m_out, m_dir, m_ier, m_isr, m_pins;
    logic        irq_hs, irq_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        case (addr[3:2])
            2'd0: m_out = lane_merge(m_out, data, strb);
            2'd1: m_dir = lane_merge(m_dir, data, strb);
            2'd2: m_ier = lane_merge(m_ier, data, strb);
            default: m_isr = m_isr & ~lane_merge(32'h0, data, strb);
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        case (addr[3:2])
            2'd0: return (m_out & m_dir) | (m_pins & ~m_dir);
            2'd1: return m_dir;
            2'd2: return m_ier;
            default: return m_isr;
        endcase
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!awready && n < 20) begin
            tick();
            n++;
        end
        check1("awready_wait", awready, 1'b1);
        check1("wready_with_aw", wready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        irq_hs = irq;
        check1("bvalid", bvalid, 1'b1);
        check("bresp", {30'b0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        irq_after = irq;
        check1("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n = 0;
        araddr = addr;
        arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        check1("arready_wait", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        check1("rvalid_wait", rvalid, 1'b1);
        check("rresp", {30'b0, rresp}, 32'd0);
        data = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        axi_write(addr, data, strb);
        model_write(addr, data, strb);
        check1("irq_after_write", irq_after, |(m_isr & m_ier));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] np;
        int          n;

        rst_n = 1'b0;
        awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b101; arvalid = 1'b0; rready = 1'b0;
        gpio_i = '0;
        m_out = '0; m_dir = '0; m_ier = '0; m_isr = '0; m_pins = '0;

        // Reset state
        repeat (3) tick();
        check("rst_handshakes", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'b0, bresp, rresp}, 32'd0);
        check("rst_gpio_o", gpio_o, 32'd0);
        check("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        check1("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Write and read back
        do_write(4'h4, 32'h0101_FFFF, 4'hF);
        do_write(4'h8, 32'hABCD_0001, 4'hF);
        do_write(4'h0, 32'h0101_FFFF, 4'hF);
        check("wr_gpio_o", gpio_o, 32'h0101_FFFF);
        check("wr_gpio_t", gpio_t, 32'hFEFE_0000);
        read_check("rd_dir", 4'h4, 32'h0101_FFFF);
        read_check("rd_ier", 4'h8, 32'hABCD_0001);

        // Byte strobes
        do_write(4'h4, 32'h0000_0000, 4'hF);
        do_write(4'h4, 32'hDEAD_0011, 4'b0011);
        read_check("rd_dir_strb", 4'h4, 32'h0000_0011);
        do_write(4'h4, 32'h0000_0000, 4'hF);

        // Edge interrupt latency and clear
        do_write(4'h8, 32'h0000_0001, 4'hF);
        gpio_i[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check1("irq_latency", irq, k >= 4);
        end
        m_pins = gpio_i;
        m_isr = m_isr | 32'h1;
        read_check("rd_isr_set", 4'hC, 32'h0000_0001);
        read_check("rd_data_in", 4'h0, model_read(4'h0));
        axi_write(4'hC, 32'h0000_0001, 4'hF);
        model_write(4'hC, 32'h0000_0001, 4'hF);
        check1("irq_at_clear", irq_hs, 1'b1);
        check1("irq_after_clear", irq_after, 1'b0);
        read_check("rd_isr_clr", 4'hC, 32'h0);

        // Collision: clear of ISR[3] lands on the same edge its new rise sets it
        gpio_i[3] = 1'b1;
        repeat (4) tick();
        gpio_i[3] = 1'b0;
        repeat (4) tick();
        m_isr = m_isr | 32'h8;
        read_check("rd_isr3_pre", 4'hC, 32'h0000_0008);
        gpio_i[3] = 1'b1;
        tick();
        axi_write(4'hC, 32'h0000_0008, 4'hF);
        m_pins = gpio_i;
        read_check("rd_isr3_collide", 4'hC, 32'h0000_0008);

        // Write backpressure: data before address, then a held response
        wdata = 32'h1234_5678; wstrb = 4'hF; awaddr = 4'h0; wvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("early_w_no_ready", {30'b0, wready, awready}, 32'd0);
        end
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            tick();
            n++;
        end
        check1("bp_awready", awready, 1'b1);
        tick();
        model_write(4'h0, 32'h1234_5678, 4'hF);
        wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 10; k++) begin
            tick();
            check1("bp_bvalid_hold", bvalid, 1'b1);
            check("bp_no_second_hs", {30'b0, awready, wready}, 32'd0);
            check("bp_gpio_o", gpio_o, 32'h1234_5678);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        bready = 1'b0;
        check1("bp_bvalid_done", bvalid, 1'b0);

        // Read backpressure
        do_write(4'h8, 32'h5A5A_00F1, 4'hF);
        araddr = 4'h8; arvalid = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            check1("rp_rvalid_hold", rvalid, 1'b1);
            check("rp_rdata_hold", rdata, 32'h5A5A_00F1);
            check1("rp_no_arready", arready, 1'b0);
        end
        arvalid = 1'b0; rready = 1'b1;
        tick();
        rready = 1'b0;
        check1("rp_rvalid_done", rvalid, 1'b0);

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    a = 4'($urandom_range(0, 15));
                    do_write(a, $urandom, 4'($urandom_range(0, 15)));
                end
                2: begin
                    a = 4'($urandom_range(0, 15));
                    read_check("rnd_read", a, model_read(a));
                end
                default: begin
                    np = $urandom;
                    gpio_i = np;
                    repeat (4) tick();
                    m_isr = m_isr | (np & ~m_pins);
                    m_pins = np;
                    check1("rnd_irq", irq, |(m_isr & m_ier));
                end
            endcase
        end
        check("rnd_gpio_o", gpio_o, m_out);
        check("rnd_gpio_t", gpio_t, ~m_dir);
        read_check("rnd_isr", 4'hC, m_isr);

        // Reset in the middle of a read
        gpio_i = '0;
        m_pins = '0;
        repeat (4) tick();
        do_write(4'h4, 32'hFFFF_0000, 4'hF);
        do_write(4'h0, 32'hA5A5_A5A5, 4'hF);
        araddr = 4'h4; arvalid = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        arvalid = 1'b0;
        check1("mid_rvalid_up", rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_rvalid", rvalid, 1'b0);
        check1("mid_rst_arready", arready, 1'b0);
        check("mid_rst_gpio_o", gpio_o, 32'd0);
        check("mid_rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        check1("mid_rst_irq", irq, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        m_out = '0; m_dir = '0; m_ier = '0; m_isr = '0;
        repeat (2) tick();
        check1("post_rst_rvalid", rvalid, 1'b0);
        read_check("post_rst_dir", 4'h4, 32'd0);
        read_check("post_rst_ier", 4'h8, 32'd0);
        read_check("post_rst_isr", 4'hC, 32'd0);
        read_check("post_rst_data", 4'h0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
